// File: rtl/spi_line_fill_arbiter.sv
// ---------------------------------------------------------------------------
// spi_line_fill_arbiter
//
// Shares one SPI master port between I-cache line refills and D-cache line
// refills / dirty-victim write-backs. One requester is granted at a time
// (round-robin on a tie) and a whole cache line is moved as LINE_WORDS word
// beats over the spi_addr_valid / spi_ready handshake. Fetched words are
// streamed into the granted cache's refill port one cycle after each beat.
//
// Optional build macro: CRITICAL_WORD_FIRST_EN
//   defined   - FILL starts at the missed word and wraps within the line
//   undefined - FILL always runs from the line base, ascending
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req, i_addr       I-cache refill request (level) and miss address
//   d_req, d_addr       D-cache request (level) and miss address
//   d_wb, d_wb_addr     victim dirty flag (sampled at grant), victim address
//   d_wb_data, wb_idx   victim word / index of the word being written back
//   i_grant, d_grant    transaction in progress for that cache
//   refill_we/addr/data refill word write into the granted cache
//   refill_done_i/_d    one-cycle line-complete pulses
//   spi_address, spi_store, write_strobe, spi_addr_valid  beat request
//   spi_fetch, spi_ready                                  beat response
// ---------------------------------------------------------------------------
module spi_line_fill_arbiter #(
    parameter  int LINE_WORDS = 4,
    parameter  int ADDR_W     = 32,
    localparam int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wb,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [31:0]       d_wb_data,
    output logic [CNT_W-1:0]  wb_idx,
    output logic              i_grant,
    output logic              d_grant,
    output logic              refill_we,
    output logic [ADDR_W-1:0] refill_addr,
    output logic [31:0]       refill_data,
    output logic              refill_done_i,
    output logic              refill_done_d,
    output logic [ADDR_W-1:0] spi_address,
    output logic [31:0]       spi_store,
    output logic [3:0]        write_strobe,
    output logic              spi_addr_valid,
    input  logic [31:0]       spi_fetch,
    input  logic              spi_ready
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   fill_base_q, fill_base_d;
    logic [ADDR_W-1:0]   wb_base_q, wb_base_d;
    logic                i_grant_q, i_grant_d;
    logic                d_grant_q, d_grant_d;
    // 1 when D was the last requester served; reset to 0 so D wins the first tie
    logic                last_d_q, last_d_d;
    logic                refill_we_q, refill_we_d;
    logic [ADDR_W-1:0]   refill_addr_q, refill_addr_d;
    logic [31:0]         refill_data_q, refill_data_d;
    logic                done_i_q, done_i_d;
    logic                done_d_q, done_d_d;
    logic [CNT_W-1:0]    fill_idx;
    logic                beat;
    logic                pick_d;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [CNT_W-1:0]    start_q, start_d;
    // Counter wraps modulo LINE_WORDS, so the sum stays within the line.
    assign fill_idx = cnt_q + start_q;
`else
    assign fill_idx = cnt_q;
`endif

    function automatic logic [ADDR_W-1:0] word_off(input logic [CNT_W-1:0] idx);
        return ADDR_W'({idx, 2'b00});
    endfunction

    // Beat-request outputs decode straight from state so they hold steady
    // while the SPI master stalls and clear immediately on reset.
    always_comb begin
        spi_addr_valid = 1'b0;
        spi_address    = '0;
        spi_store      = '0;
        write_strobe   = 4'h0;
        wb_idx         = '0;
        case (state_q)
            WB: begin
                spi_addr_valid = 1'b1;
                spi_address    = wb_base_q + word_off(cnt_q);
                spi_store      = d_wb_data;
                write_strobe   = 4'hF;
                wb_idx         = cnt_q;
            end
            FILL: begin
                spi_addr_valid = 1'b1;
                spi_address    = fill_base_q + word_off(fill_idx);
            end
            default: ;
        endcase
    end

    assign beat   = spi_addr_valid && spi_ready;
    assign pick_d = d_req && (!i_req || !last_d_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fill_base_d   = fill_base_q;
        wb_base_d     = wb_base_q;
        i_grant_d     = i_grant_q;
        d_grant_d     = d_grant_q;
        last_d_d      = last_d_q;
        refill_we_d   = 1'b0;
        refill_addr_d = refill_addr_q;
        refill_data_d = refill_data_q;
        done_i_d      = 1'b0;
        done_d_d      = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
        start_d       = start_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_d) begin
                    d_grant_d   = 1'b1;
                    fill_base_d = d_addr & LINE_MASK;
                    wb_base_d   = d_wb_addr & LINE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d     = d_addr[CNT_W+1:2];
`endif
                    state_d     = d_wb ? WB : FILL;
                end else if (i_req) begin
                    i_grant_d   = 1'b1;
                    fill_base_d = i_addr & LINE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d     = i_addr[CNT_W+1:2];
`endif
                    state_d     = FILL;
                end
            end
            WB: begin
                if (beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FILL: begin
                if (beat) begin
                    refill_we_d   = 1'b1;
                    refill_addr_d = spi_address;
                    refill_data_d = spi_fetch;
                    cnt_d         = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        // Pulse lands in DONE together with the last refill write.
                        state_d  = DONE;
                        done_i_d = i_grant_q;
                        done_d_d = d_grant_q;
                    end
                end
            end
            DONE: begin
                i_grant_d = 1'b0;
                d_grant_d = 1'b0;
                last_d_d  = d_grant_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            fill_base_q   <= '0;
            wb_base_q     <= '0;
            i_grant_q     <= 1'b0;
            d_grant_q     <= 1'b0;
            last_d_q      <= 1'b0;
            refill_we_q   <= 1'b0;
            refill_addr_q <= '0;
            refill_data_q <= '0;
            done_i_q      <= 1'b0;
            done_d_q      <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fill_base_q   <= fill_base_d;
            wb_base_q     <= wb_base_d;
            i_grant_q     <= i_grant_d;
            d_grant_q     <= d_grant_d;
            last_d_q      <= last_d_d;
            refill_we_q   <= refill_we_d;
            refill_addr_q <= refill_addr_d;
            refill_data_q <= refill_data_d;
            done_i_q      <= done_i_d;
            done_d_q      <= done_d_d;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q       <= start_d;
`endif
        end
    end

    assign i_grant       = i_grant_q;
    assign d_grant       = d_grant_q;
    assign refill_we     = refill_we_q;
    assign refill_addr   = refill_addr_q;
    assign refill_data   = refill_data_q;
    assign refill_done_i = done_i_q;
    assign refill_done_d = done_d_q;

endmodule

// File: tb/tb_spi_line_fill_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for spi_line_fill_arbiter (LINE_WORDS=4, ADDR_W=32).
// Expected beats and refill writes for each line are built from the
// transfer rules (line base, word order, write-back first) into queues;
// the SPI slave side is driven with random stall lengths and fetch data.
// ---------------------------------------------------------------------------
module tb_spi_line_fill_arbiter;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wb;
    logic [31:0] i_addr, d_addr, d_wb_addr, d_wb_data;
    logic [1:0]  wb_idx;
    logic        i_grant, d_grant, refill_we, refill_done_i, refill_done_d;
    logic [31:0] refill_addr, refill_data, spi_address, spi_store, spi_fetch;
    logic [3:0]  write_strobe;
    logic        spi_addr_valid, spi_ready;

    logic [31:0] victim [LW];
    assign d_wb_data = victim[wb_idx];

    always #5 clk = ~clk;

    spi_line_fill_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_wb(d_wb), .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
        .wb_idx(wb_idx),
        .i_grant(i_grant), .d_grant(d_grant),
        .refill_we(refill_we), .refill_addr(refill_addr), .refill_data(refill_data),
        .refill_done_i(refill_done_i), .refill_done_d(refill_done_d),
        .spi_address(spi_address), .spi_store(spi_store),
        .write_strobe(write_strobe), .spi_addr_valid(spi_addr_valid),
        .spi_fetch(spi_fetch), .spi_ready(spi_ready)
    );

    typedef struct { logic [31:0] addr; bit wr; int idx; } beat_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } refill_t;

    beat_t   beatq[$];
    refill_t refq[$];
    int      errors = 0;
    int      checks = 0;
    bit      last_d = 1'b0;   // model: D served most recently
    int      txn_no = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {i_grant, d_grant, refill_we, refill_done_i, refill_done_d,
                            spi_addr_valid, write_strobe, wb_idx}, 64'h0);
        chk({tag, "_refill_addr"}, refill_addr, 64'h0);
        chk({tag, "_refill_data"}, refill_data, 64'h0);
        chk({tag, "_spi_address"}, spi_address, 64'h0);
        chk({tag, "_spi_store"}, spi_store, 64'h0);
    endtask

    // k-th fill beat address for a miss at a
    function automatic logic [31:0] fill_addr(input logic [31:0] a, input int k);
        logic [31:0] base;
        int          start;
        base  = a & ~32'hF;
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(a[3:2]);
`else
        start = 0;
`endif
        return base + 32'(((start + k) % LW) * 4);
    endfunction

    // Runs one granted line. Requests are already driven; the grant is
    // expected one cycle later. stall<0 picks a random 0..2 stall per beat.
    task automatic run_line(input bit exp_d, input int stall, input bit chk_lat);
        logic [31:0] a;
        bit          wb, done_seen;
        int          waitc, need;
        a  = exp_d ? d_addr : i_addr;
        wb = exp_d && d_wb;
        for (int k = 0; k < LW; k++) victim[k] = $urandom;
        beatq.delete();
        refq.delete();
        if (wb)
            for (int k = 0; k < LW; k++)
                beatq.push_back('{(d_wb_addr & ~32'hF) + 32'(k * 4), 1'b1, k});
        for (int k = 0; k < LW; k++) beatq.push_back('{fill_addr(a, k), 1'b0, k});
        txn_no++;
        $display("txn %0d: grant=%s addr=%h wb=%0d wb_addr=%h stall=%0d",
                 txn_no, exp_d ? "D" : "I", a, wb, d_wb_addr, stall);
        waitc     = 0;
        need      = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        done_seen = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            chk("i_grant", i_grant, !exp_d);
            chk("d_grant", d_grant, exp_d);
            if (refill_we) begin
                chk("refill_pending", refq.size() > 0, 1);
                if (refq.size() > 0) begin
                    chk("refill_addr", refill_addr, refq[0].addr);
                    chk("refill_data", refill_data, refq[0].data);
                    void'(refq.pop_front());
                end
            end
            if (refill_done_i || refill_done_d) begin
                chk("done_i", refill_done_i, !exp_d);
                chk("done_d", refill_done_d, exp_d);
                chk("beats_left", beatq.size(), 0);
                chk("refills_left", refq.size(), 0);
                if (chk_lat) chk("latency", cyc + 1, LW + 2);
                done_seen = 1'b1;
                break;
            end
            chk("valid", spi_addr_valid, beatq.size() > 0);
            if (spi_addr_valid && beatq.size() > 0) begin
                chk("spi_address", spi_address, beatq[0].addr);
                chk("write_strobe", write_strobe, beatq[0].wr ? 4'hF : 4'h0);
                if (beatq[0].wr) begin
                    chk("wb_idx", wb_idx, beatq[0].idx);
                    chk("spi_store", spi_store, victim[beatq[0].idx]);
                end
                if (waitc >= need) begin
                    spi_ready = 1'b1;
                    spi_fetch = $urandom;
                    if (!beatq[0].wr) refq.push_back('{beatq[0].addr, spi_fetch});
                    void'(beatq.pop_front());
                    waitc = 0;
                    need  = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                end else begin
                    spi_ready = 1'b0;
                    waitc++;
                end
            end else begin
                // ready without a valid beat must be ignored
                spi_ready = 1'($urandom_range(0, 1));
                spi_fetch = $urandom;
            end
        end
        chk("done_seen", done_seen, 1);
        if (exp_d) begin d_req = 1'b0; d_wb = 1'b0; end
        else i_req = 1'b0;
        spi_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {i_grant, d_grant, refill_done_i, refill_done_d,
                                spi_addr_valid, refill_we}, 64'h0);
        last_d = exp_d;
    endtask

    initial begin
        int  r;
        bit  ed;
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wb = 1'b0;
        i_addr = '0; d_addr = '0; d_wb_addr = '0;
        spi_ready = 1'b0; spi_fetch = '0;
        for (int k = 0; k < LW; k++) victim[k] = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // simultaneous requests after reset: D first, then I; then again
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_5678; d_addr = 32'h0000_9AB4;
        run_line(1'b1, 0, 1'b0);
        run_line(1'b0, 0, 1'b0);
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0104; d_addr = 32'h0000_0F0C;
        ed = d_req && (!i_req || !last_d);
        run_line(ed, 0, 1'b0);
        run_line(!ed, 0, 1'b0);

        // single I miss, spi_ready held high: minimum latency
        i_req = 1'b1; i_addr = 32'h0000_1234;
        run_line(1'b0, 0, 1'b1);

        // dirty D victim: write-back then fill
        d_req = 1'b1; d_wb = 1'b1; d_wb_addr = 32'h0000_8000; d_addr = 32'h0000_4010;
        run_line(1'b1, 0, 1'b0);

        // three stall cycles per beat
        i_req = 1'b1; i_addr = 32'h0000_0F08;
        run_line(1'b0, 3, 1'b0);
        d_req = 1'b1; d_wb = 1'b1; d_wb_addr = 32'hFFFF_FFF4; d_addr = 32'h0000_2A2C;
        run_line(1'b1, 3, 1'b0);

        // reset during the second fill beat
        i_req = 1'b1; i_addr = 32'h0000_2224; spi_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_second_beat", spi_address, fill_addr(i_addr, 1));
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        i_req = 1'b0; spi_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_reset", {i_grant, d_grant, refill_done_i, refill_done_d,
                                        refill_we}, 64'h0);
        end
        last_d = 1'b0;
        i_req = 1'b1;
        run_line(1'b0, 0, 1'b1);

        // random requester mix, addresses and stalls
        for (int t = 0; t < 12; t++) begin
            if (!i_req && !d_req) begin
                r = int'($urandom_range(1, 3));
                if (r[0]) begin i_req = 1'b1; i_addr = $urandom; end
                if (r[1]) begin
                    d_req = 1'b1; d_addr = $urandom; d_wb_addr = $urandom;
                    d_wb = 1'($urandom_range(0, 1));
                end
            end else if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1; i_addr = $urandom;
            end else if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_addr = $urandom; d_wb_addr = $urandom;
                d_wb = 1'($urandom_range(0, 1));
            end
            ed = d_req && (!i_req || !last_d);
            run_line(ed, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
